sequence_generator: RTL and testbench

Serial pattern transmitter: on a start pulse, emits a parameterised bit pattern MSB-first, repeated a programmable number of times with optional zero-filled gaps. Output uses a valid/ready handshake. It is the stimulus and transmit-side counterpart of the serial sequence detectors in this codebase: it drives the single-bit `a` stream those detectors consume.

---
 rtl/sequence_pkg.sv | 13 +
 rtl/sequence_generator.sv | 139 +++++++++++++
 tb/tb_sequence_generator.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_pkg.sv
// Shared constants for the serial pattern blocks: FSM state
// encoding and the default pattern the detectors look for.
package sequence_pkg;

  localparam int          STATE_W     = 2;
  localparam logic [1:0]  IDLE        = 2'd0;
  localparam logic [1:0]  SEND        = 2'd1;
  localparam logic [1:0]  GAP         = 2'd2;

  localparam int          DEF_PAT_W   = 6;
  localparam logic [5:0]  DEF_PATTERN = 6'b101101;

endpackage

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends PATTERN MSB-first, repeated
// repeat_n times with gap zero bits between repetitions.
// Ports: clk, rstn (sync, active-low), start, repeat_n, gap,
//        a / a_valid / a_ready (valid-ready stream), busy, done.
module sequence_generator
  import sequence_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PAT_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN,
  parameter int                   CNT_W     = 8,
  parameter int                   GAP_W     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             a,
  output logic             a_valid,
  input  logic             a_ready,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W = $clog2(PATTERN_W);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [GAP_W-1:0] GONE  = GAP_W'(1);

  logic [STATE_W-1:0] r_state;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [CNT_W-1:0]   r_rep_left;
  logic [GAP_W-1:0]   r_gap_left;
  logic [GAP_W-1:0]   r_gap_q;
  logic               r_done;

  logic [STATE_W-1:0] w_state_d;
  logic [IDX_W-1:0]   w_bit_idx_d;
  logic [CNT_W-1:0]   w_rep_left_d;
  logic [GAP_W-1:0]   w_gap_left_d;
  logic [GAP_W-1:0]   w_gap_q_d;
  logic               w_done_d;
  logic               w_xfer;

  // a_valid is decoded from state only, so the handshake has
  // no combinational path from a_ready to any output.
  assign w_xfer = a_valid && a_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_bit_idx  <= '0;
      r_rep_left <= '0;
      r_gap_left <= '0;
      r_gap_q    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_bit_idx  <= w_bit_idx_d;
      r_rep_left <= w_rep_left_d;
      r_gap_left <= w_gap_left_d;
      r_gap_q    <= w_gap_q_d;
      r_done     <= w_done_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_bit_idx_d  = r_bit_idx;
    w_rep_left_d = r_rep_left;
    w_gap_left_d = r_gap_left;
    w_gap_q_d    = r_gap_q;
    w_done_d     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_d    = SEND;
          w_bit_idx_d  = LAST;
          w_rep_left_d = (repeat_n == '0) ? ONE : repeat_n;
          w_gap_q_d    = gap;
        end
      end
      SEND: begin
        if (w_xfer) begin
          if (r_bit_idx != '0) begin
            w_bit_idx_d = r_bit_idx - 1'b1;
          end else if (r_rep_left == ONE) begin
            w_state_d    = IDLE;
            w_rep_left_d = '0;
            w_done_d     = 1'b1;
          end else begin
            w_rep_left_d = r_rep_left - ONE;
            w_bit_idx_d  = LAST;
            if (r_gap_q != '0) begin
              w_state_d    = GAP;
              w_gap_left_d = r_gap_q;
            end
          end
        end
      end
      GAP: begin
        if (w_xfer) begin
          w_gap_left_d = r_gap_left - GONE;
          if (r_gap_left == GONE) begin
            w_state_d = SEND;
          end
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    a       = 1'b0;
    a_valid = 1'b0;
    busy    = 1'b0;
    unique case (r_state)
      SEND: begin
        a       = PATTERN[r_bit_idx];
        a_valid = 1'b1;
        busy    = 1'b1;
      end
      GAP: begin
        a_valid = 1'b1;
        busy    = 1'b1;
      end
      default: begin
        a       = 1'b0;
        a_valid = 1'b0;
        busy    = 1'b0;
      end
    endcase
  end

  assign done = r_done;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: scoreboard of
// expected serial bits plus a software 101101 detector.
module tb_sequence_generator;

  localparam logic [5:0] PAT = 6'b101101;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [7:0] repeat_n;
  logic [3:0] gap;
  logic       a;
  logic       a_valid;
  logic       a_ready;
  logic       busy;
  logic       done;

  int   errors = 0;
  int   checks = 0;
  bit   exp_q[$];
  logic [5:0] det_sr;
  int   det_n;
  int   det_hits;

  sequence_generator dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .repeat_n (repeat_n),
    .gap      (gap),
    .a        (a),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic det_clear();
    det_sr   = '0;
    det_n    = 0;
    det_hits = 0;
  endtask

  task automatic push_pattern(input int n, input int g);
    int eff;
    eff = (n == 0) ? 1 : n;
    for (int r = 0; r < eff; r++) begin
      for (int i = 5; i >= 0; i--) exp_q.push_back(PAT[i]);
      if (r < eff - 1)
        for (int z = 0; z < g; z++) exp_q.push_back(1'b0);
    end
  endtask

  task automatic do_start(input int n, input int g);
    repeat_n = 8'(n);
    gap      = 4'(g);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Runs from cycle 1 (first bit valid) until done; returns in
  // the done cycle. Pops the scoreboard on every transfer.
  task automatic drain(input int maxc, input bit tog,
                       input bit mid_start,
                       output int nvalid, output int donec);
    logic pa;
    bit   pstall;
    bit   eb;
    nvalid = 0;
    donec  = 0;
    pstall = 0;
    pa     = 1'b0;
    for (int c = 1; c <= maxc; c++) begin
      a_ready = tog ? ((c % 4 == 1) || (c % 4 == 0)) : 1'b1;
      start   = mid_start && (c == 4);
      if (pstall) begin
        checks++;
        if (a_valid !== 1'b1 || a !== pa) begin
          errors++;
          $display("FAIL hold c=%0d a=%b valid=%b want a=%b valid=1",
                   c, a, a_valid, pa);
        end
      end
      if (done === 1'b1) begin
        donec = c;
        checks++;
        if (busy !== 1'b0 || a_valid !== 1'b0) begin
          errors++;
          $display("FAIL done_idle busy=%b valid=%b want 0 0",
                   busy, a_valid);
        end
        break;
      end
      if (a_valid === 1'b1) begin
        nvalid++;
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy c=%0d got %b want 1", c, busy);
        end
      end
      if (a_valid === 1'b1 && a_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_bit c=%0d got a=%b want none", c, a);
        end else begin
          eb = exp_q.pop_front();
          if (a !== eb) begin
            errors++;
            $display("FAIL bit c=%0d got %b want %b", c, a, eb);
          end
        end
        det_sr = {det_sr[4:0], a};
        det_n++;
        if (det_n >= 6 && det_sr == PAT) det_hits++;
      end
      pstall = (a_valid === 1'b1) && (a_ready === 1'b0);
      pa     = a;
      tick();
    end
    start   = 1'b0;
    a_ready = 1'b1;
    if (donec == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout no done within %0d cycles", maxc);
    end
  endtask

  task automatic check_run(input string nm, input int nv, input int dc,
                           input int want_nv, input int want_dc,
                           input int want_hits);
    checks++;
    if (nv != want_nv) begin
      errors++;
      $display("FAIL %s valid_cycles got %0d want %0d", nm, nv, want_nv);
    end
    checks++;
    if (dc != want_dc) begin
      errors++;
      $display("FAIL %s done_cycle got %0d want %0d", nm, dc, want_dc);
    end
    checks++;
    if (det_hits != want_hits) begin
      errors++;
      $display("FAIL %s detector_hits got %0d want %0d",
               nm, det_hits, want_hits);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover_bits got %0d want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    checks++;
    if ({a, a_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset a/valid/busy/done got %b want 0000",
               {a, a_valid, busy, done});
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int nv, dc;
    det_clear();
    push_pattern(1, 0);
    do_start(1, 0);
    drain(40, 1'b0, 1'b0, nv, dc);
    check_run("single", nv, dc, 6, 7, 1);
    tick();
  endtask

  task automatic test_repeat2();
    int nv, dc;
    det_clear();
    push_pattern(2, 0);
    do_start(2, 0);
    drain(60, 1'b0, 1'b0, nv, dc);
    check_run("repeat2", nv, dc, 12, 13, 3);
    tick();
  endtask

  task automatic test_gap();
    int nv, dc;
    det_clear();
    push_pattern(2, 3);
    do_start(2, 3);
    drain(60, 1'b0, 1'b0, nv, dc);
    check_run("gap3", nv, dc, 15, 16, 2);
    tick();
  endtask

  task automatic test_stall();
    int nv, dc;
    det_clear();
    push_pattern(1, 0);
    do_start(1, 0);
    drain(80, 1'b1, 1'b1, nv, dc);
    check_run("stall", nv, nv + 1, nv, nv + 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (a_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_idle got valid=%b want 0", a_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nv, dc;
    det_clear();
    push_pattern(0, 0);
    do_start(0, 0);
    drain(40, 1'b0, 1'b0, nv, dc);
    check_run("rep0", nv, dc, 6, 7, 1);
    det_clear();
    push_pattern(0, 0);
    do_start(0, 0);
    checks++;
    if (a_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start valid=%b busy=%b want 1 1",
               a_valid, busy);
    end
    drain(40, 1'b0, 1'b0, nv, dc);
    check_run("b2b", nv, dc, 6, 7, 1);
    tick();
  endtask

  task automatic test_reset_mid();
    int nv, dc;
    do_start(1, 0);
    tick();
    tick();
    checks++;
    if (a !== 1'b1 || a_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit3 a=%b valid=%b want 1 1", a, a_valid);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checks++;
    if ({a, a_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset a/valid/busy/done got %b want 0000",
               {a, a_valid, busy, done});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || a_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_abort done=%b valid=%b want 0 0",
                 done, a_valid);
      end
    end
    det_clear();
    push_pattern(1, 0);
    do_start(1, 0);
    drain(40, 1'b0, 1'b0, nv, dc);
    check_run("after_reset", nv, dc, 6, 7, 1);
    tick();
  endtask

  initial begin
    rstn     = 1'b0;
    start    = 1'b0;
    repeat_n = '0;
    gap      = '0;
    a_ready  = 1'b1;
    det_clear();
    test_reset();
    test_single();
    test_repeat2();
    test_gap();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
